// File: rtl/register_bank_if.sv
// Bus bundle for register_bank: control/op inputs and the two read ports.
//   master : drives sclr, sset, op, waddr, pin, sin, raddr_a, raddr_b
//            and observes pout_a, pout_b, zero_a, ovf, sout
//   slave  : the register bank side of the same signals
interface register_bank_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) ();
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             sclr;
  logic             sset;
  logic [2:0]       op;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] pin;
  logic             sin;
  logic [AW-1:0]    raddr_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] pout_a;
  logic [WIDTH-1:0] pout_b;
  logic             zero_a;
  logic [DEPTH-1:0] ovf;
  logic             sout;

  modport master (
    output sclr, sset, op, waddr, pin, sin, raddr_a, raddr_b,
    input  pout_a, pout_b, zero_a, ovf, sout
  );

  modport slave (
    input  sclr, sset, op, waddr, pin, sin, raddr_a, raddr_b,
    output pout_a, pout_b, zero_a, ovf, sout
  );
endinterface

// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH register file applying one operation per cycle
// (load/clear/set/shift/inc/dec) to the addressed entry, with global clear/set,
// sticky per-entry overflow flags and a serial-out bit from the last shift.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - register_bank_if.slave: sclr, sset, op, waddr, pin, sin,
//          raddr_a, raddr_b in; pout_a, pout_b, zero_a, ovf, sout out
// Read ports are combinational from the stored entries (no write bypass).
module register_bank #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] SET_VALUE = 32'h0000_0100,
  parameter bit          SATURATE  = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  register_bank_if.slave bus
);

  localparam logic [WIDTH-1:0] SET_W = WIDTH'(SET_VALUE);

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_LOAD  = 3'b001,
    OP_CLEAR = 3'b010,
    OP_SET   = 3'b011,
    OP_SHL   = 3'b100,
    OP_SHR   = 3'b101,
    OP_INC   = 3'b110,
    OP_DEC   = 3'b111
  } op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0] ovf_q;
  logic             sout_q;

  op_e              op;
  logic             w_in_range;
  logic [WIDTH-1:0] w_cur;
  logic             w_en;
  logic [WIDTH-1:0] w_val;
  logic [DEPTH-1:0] ovf_d;
  logic             sout_d;

  assign op         = op_e'(bus.op);
  assign w_in_range = (32'(bus.waddr) < DEPTH);
  assign w_cur      = w_in_range ? mem_q[bus.waddr] : '0;

  // Next value of the addressed entry, its overflow flag and sout
  always_comb begin
    w_en   = 1'b0;
    w_val  = w_cur;
    ovf_d  = ovf_q;
    sout_d = sout_q;
    if (w_in_range) begin
      case (op)
        OP_LOAD: begin
          w_en  = 1'b1;
          w_val = bus.pin;
        end
        OP_CLEAR: begin
          w_en               = 1'b1;
          w_val              = '0;
          ovf_d[bus.waddr]   = 1'b0;
        end
        OP_SET: begin
          w_en               = 1'b1;
          w_val              = SET_W;
          ovf_d[bus.waddr]   = 1'b0;
        end
        OP_SHL: begin
          w_en   = 1'b1;
          w_val  = {w_cur[WIDTH-2:0], bus.sin};
          sout_d = w_cur[WIDTH-1];
        end
        OP_SHR: begin
          w_en   = 1'b1;
          w_val  = {bus.sin, w_cur[WIDTH-1:1]};
          sout_d = w_cur[0];
        end
        OP_INC: begin
          w_en = 1'b1;
          if (&w_cur) begin
            // Overflow is flagged whether the value wraps or saturates
            w_val            = SATURATE ? w_cur : '0;
            ovf_d[bus.waddr] = 1'b1;
          end else begin
            w_val = w_cur + WIDTH'(1);
          end
        end
        OP_DEC: begin
          w_en = 1'b1;
          if (w_cur == '0) begin
            w_val            = SATURATE ? '0 : '1;
            ovf_d[bus.waddr] = 1'b1;
          end else begin
            w_val = w_cur - WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // State update; rst > sclr > sset > op
  always_ff @(posedge clk) begin
    if (rst || bus.sclr) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      ovf_q  <= '0;
      sout_q <= 1'b0;
    end else if (bus.sset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= SET_W;
      end
      ovf_q <= '0;
    end else begin
      if (w_en) begin
        mem_q[bus.waddr] <= w_val;
      end
      ovf_q  <= ovf_d;
      sout_q <= sout_d;
    end
  end

  // Read ports; an address beyond the last entry reads as zero
  logic [WIDTH-1:0] rd_a;
  logic [WIDTH-1:0] rd_b;

  assign rd_a = (32'(bus.raddr_a) < DEPTH) ? mem_q[bus.raddr_a] : '0;
  assign rd_b = (32'(bus.raddr_b) < DEPTH) ? mem_q[bus.raddr_b] : '0;

  assign bus.pout_a = rd_a;
  assign bus.pout_b = rd_b;
  assign bus.zero_a = (rd_a == '0);
  assign bus.ovf    = ovf_q;
  assign bus.sout   = sout_q;

endmodule

// File: tb/tb_register_bank.sv
// Bench for register_bank: three builds (wrap, saturate, 3-entry) share one
// stimulus stream and are checked each cycle against an array-based model.
module tb_register_bank;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        sclr, sset, sin;
  logic [2:0]  op;
  logic [1:0]  waddr, raddr_a, raddr_b;
  logic [15:0] pin;

  register_bank_if #(.WIDTH(16), .DEPTH(4)) bus0 ();
  register_bank_if #(.WIDTH(16), .DEPTH(4)) bus1 ();
  register_bank_if #(.WIDTH(16), .DEPTH(3)) bus2 ();

  assign bus0.sclr = sclr; assign bus0.sset = sset; assign bus0.op = op; assign bus0.waddr = waddr;
  assign bus0.pin = pin; assign bus0.sin = sin; assign bus0.raddr_a = raddr_a; assign bus0.raddr_b = raddr_b;
  assign bus1.sclr = sclr; assign bus1.sset = sset; assign bus1.op = op; assign bus1.waddr = waddr;
  assign bus1.pin = pin; assign bus1.sin = sin; assign bus1.raddr_a = raddr_a; assign bus1.raddr_b = raddr_b;
  assign bus2.sclr = sclr; assign bus2.sset = sset; assign bus2.op = op; assign bus2.waddr = waddr;
  assign bus2.pin = pin; assign bus2.sin = sin; assign bus2.raddr_a = raddr_a; assign bus2.raddr_b = raddr_b;

  register_bank #(.WIDTH(16), .DEPTH(4), .SET_VALUE(32'h0100), .SATURATE(1'b0))
    dut0 (.clk(clk), .rst(rst), .bus(bus0.slave));
  register_bank #(.WIDTH(16), .DEPTH(4), .SET_VALUE(32'h0100), .SATURATE(1'b1))
    dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  register_bank #(.WIDTH(16), .DEPTH(3), .SET_VALUE(32'h0100), .SATURATE(1'b0))
    dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, CLR = 3'd2, SET = 3'd3,
                         SHL = 3'd4, SHR = 3'd5, INC = 3'd6, DEC = 3'd7;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer entries per build
  int unsigned cfg_depth [3] = '{4, 4, 3};
  bit          cfg_sat   [3] = '{1'b0, 1'b1, 1'b0};
  int unsigned m_ent [3][4];
  logic [3:0]  m_ovf [3];
  bit          m_sout [3];

  function automatic int unsigned model_rd(input int c, input int a);
    if (a >= int'(cfg_depth[c])) return 0;
    return m_ent[c][a];
  endfunction

  task automatic model_step();
    int unsigned v;
    int a;
    a = int'(waddr);
    for (int c = 0; c < 3; c++) begin
      if (rst || sclr) begin
        for (int i = 0; i < 4; i++) m_ent[c][i] = 0;
        m_ovf[c] = 4'b0;
        m_sout[c] = 1'b0;
      end else if (sset) begin
        for (int i = 0; i < int'(cfg_depth[c]); i++) m_ent[c][i] = 32'h0100;
        m_ovf[c] = 4'b0;
      end else if (a < int'(cfg_depth[c])) begin
        v = m_ent[c][a];
        case (op)
          LOAD: v = 32'(pin);
          CLR:  begin v = 0; m_ovf[c][a] = 1'b0; end
          SET:  begin v = 32'h0100; m_ovf[c][a] = 1'b0; end
          SHL:  begin m_sout[c] = v[15]; v = ((v * 2) + 32'(sin)) % 65536; end
          SHR:  begin m_sout[c] = v[0]; v = (v / 2) + (sin ? 32768 : 0); end
          INC:  if (v == 65535) begin m_ovf[c][a] = 1'b1; v = cfg_sat[c] ? 65535 : 0; end
                else v = v + 1;
          DEC:  if (v == 0) begin m_ovf[c][a] = 1'b1; v = cfg_sat[c] ? 0 : 65535; end
                else v = v - 1;
          default: ;
        endcase
        m_ent[c][a] = v;
      end
    end
  endtask

  function automatic logic [31:0] get_pa(input int c);
    case (c) 0: return 32'(bus0.pout_a); 1: return 32'(bus1.pout_a); default: return 32'(bus2.pout_a); endcase
  endfunction
  function automatic logic [31:0] get_pb(input int c);
    case (c) 0: return 32'(bus0.pout_b); 1: return 32'(bus1.pout_b); default: return 32'(bus2.pout_b); endcase
  endfunction
  function automatic logic [31:0] get_za(input int c);
    case (c) 0: return 32'(bus0.zero_a); 1: return 32'(bus1.zero_a); default: return 32'(bus2.zero_a); endcase
  endfunction
  function automatic logic [31:0] get_ovf(input int c);
    case (c) 0: return 32'(bus0.ovf); 1: return 32'(bus1.ovf); default: return 32'(bus2.ovf); endcase
  endfunction
  function automatic logic [31:0] get_sout(input int c);
    case (c) 0: return 32'(bus0.sout); 1: return 32'(bus1.sout); default: return 32'(bus2.sout); endcase
  endfunction

  task automatic check(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h (t=%0t)", nm, c, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every build against the model
  task automatic compare_all();
    int unsigned ea;
    for (int c = 0; c < 3; c++) begin
      ea = model_rd(c, int'(raddr_a));
      check("pout_a", c, get_pa(c), ea);
      check("pout_b", c, get_pb(c), model_rd(c, int'(raddr_b)));
      check("zero_a", c, get_za(c), (ea == 0) ? 32'd1 : 32'd0);
      check("ovf", c, get_ovf(c), 32'(m_ovf[c]));
      check("sout", c, get_sout(c), 32'(m_sout[c]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic drive(input logic s_clr, input logic s_set, input logic [2:0] o,
                       input int wa, input logic [15:0] d, input logic si);
    sclr = s_clr; sset = s_set; op = o; waddr = 2'(wa); pin = d; sin = si;
    raddr_a = 2'($urandom_range(0, 3));
    raddr_b = 2'($urandom_range(0, 3));
    tick();
  endtask

  // Hand-computed expectation of one entry through read port A
  task automatic lit(input string nm, input int c, input int a, input logic [31:0] exp);
    raddr_a = 2'(a);
    #1;
    check(nm, c, get_pa(c), exp);
  endtask

  task automatic rand_traffic(input int n);
    logic [15:0] d;
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 4))
        0: d = 16'h0000;
        1: d = 16'hFFFF;
        2: d = 16'hFFFE;
        3: d = 16'h0001;
        default: d = 16'($urandom);
      endcase
      drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 39) == 0),
            3'($urandom_range(0, 7)), int'($urandom_range(0, 3)), d, 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1; sclr = 1'b0; sset = 1'b0; op = NOP; waddr = '0;
    pin = '0; sin = 1'b0; raddr_a = '0; raddr_b = '0;
    drive(1'b0, 1'b0, NOP, 0, 16'h0, 1'b0);
    rst = 1'b0;
    rand_traffic(300);

    // Reset after traffic
    rst = 1'b1;
    drive(1'b0, 1'b0, NOP, 0, 16'h0, 1'b0);
    rst = 1'b0;
    for (int a = 0; a < 4; a++) lit("rst_entry", 0, a, 32'h0);
    check("rst_ovf", 0, get_ovf(0), 32'h0);
    check("rst_sout", 0, get_sout(0), 32'h0);
    check("rst_zero_a", 0, get_za(0), 32'h1);

    drive(1'b0, 1'b1, NOP, 0, 16'h0, 1'b0);
    for (int a = 0; a < 4; a++) lit("sset_entry", 0, a, 32'h0100);
    check("sset_ovf", 0, get_ovf(0), 32'h0);

    // Shifts
    drive(1'b0, 1'b0, LOAD, 2, 16'hA5A5, 1'b0);
    drive(1'b0, 1'b0, SHL, 2, 16'h0, 1'b1);
    lit("shl_entry", 0, 2, 32'h4B4B);
    check("shl_sout", 0, get_sout(0), 32'h1);
    drive(1'b0, 1'b0, SHR, 2, 16'h0, 1'b0);
    lit("shr_entry", 0, 2, 32'h25A5);
    check("shr_sout", 0, get_sout(0), 32'h1);

    // Wrap overflow, sticky through LOAD, cleared by CLEAR
    drive(1'b0, 1'b0, LOAD, 1, 16'hFFFF, 1'b0);
    drive(1'b0, 1'b0, INC, 1, 16'h0, 1'b0);
    lit("inc_wrap", 0, 1, 32'h0);
    check("inc_wrap_ovf", 0, get_ovf(0), 32'h2);
    drive(1'b0, 1'b0, LOAD, 1, 16'h0005, 1'b0);
    check("load_keeps_ovf", 0, get_ovf(0), 32'h2);
    drive(1'b0, 1'b0, CLR, 1, 16'h0, 1'b0);
    check("clear_ovf", 0, get_ovf(0), 32'h0);

    // Saturating build
    drive(1'b1, 1'b0, NOP, 0, 16'h0, 1'b0);
    drive(1'b0, 1'b0, DEC, 0, 16'h0, 1'b0);
    lit("sat_dec", 1, 0, 32'h0);
    check("sat_dec_ovf", 1, get_ovf(1), 32'h1);
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, INC, 0, 16'h0, 1'b0);
    lit("sat_inc5", 1, 0, 32'h5);
    check("sat_inc5_ovf", 1, get_ovf(1), 32'h1);

    // Priority: sclr over sset over op
    drive(1'b1, 1'b1, LOAD, 0, 16'h1234, 1'b0);
    for (int a = 0; a < 4; a++) lit("sclr_prio", 0, a, 32'h0);
    drive(1'b0, 1'b1, INC, 0, 16'h0, 1'b0);
    for (int a = 0; a < 4; a++) lit("sset_prio", 0, a, 32'h0100);

    // Out-of-range write/read on the 3-entry build
    drive(1'b0, 1'b0, LOAD, 3, 16'hBEEF, 1'b0);
    lit("oor_read", 2, 3, 32'h0);
    check("oor_zero_a", 2, get_za(2), 32'h1);
    for (int a = 0; a < 3; a++) lit("oor_no_write", 2, a, 32'h0100);
    lit("in_range_write", 0, 3, 32'hBEEF);

    rand_traffic(400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/register_bank.md
Name: register_bank

Overview:
- Parametrised multi-entry successor of the single 16-bit load/clear/set register.
- Holds DEPTH entries of WIDTH bits and applies one per-cycle operation to an addressed entry: load, clear, set, shift, increment or decrement.
- Keeps the global clear/set of the earlier block and adds sticky overflow flags per entry.
- Feeds datapath counters and shift chains that previously needed several discrete registers.

Parameters:
- WIDTH, 16, bits per entry (>=2).
- DEPTH, 4, number of entries (>=1). AW = max(1, $clog2(DEPTH)).
- SET_VALUE, 16'h0100, value written by SET op and by sset (truncated/zero-extended to WIDTH).
- SATURATE, 0, INC/DEC overflow handling: 0 = wrap, 1 = saturate.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- sclr  input  1  synchronous clear of all entries and flags.
- sset  input  1  synchronous set of all entries to SET_VALUE; clears all flags.
- op  input  3  operation on entry waddr: 000 NOP, 001 LOAD, 010 CLEAR, 011 SET, 100 SHL, 101 SHR, 110 INC, 111 DEC.
- waddr  input  AW  target entry.
- pin  input  WIDTH  LOAD data.
- sin  input  1  serial-in bit for SHL/SHR.
- raddr_a  input  AW  read address, port A.
- raddr_b  input  AW  read address, port B.
- pout_a  output  WIDTH  entry[raddr_a].
- pout_b  output  WIDTH  entry[raddr_b].
- zero_a  output  1  high when pout_a == 0.
- ovf  output  DEPTH  sticky per-entry overflow flags.
- sout  output  1  bit shifted out by the most recent SHL/SHR.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All state updates on the rising edge of clk.
- Priority per cycle: rst > sclr > sset > op.
- rst: all entries = 0, ovf = 0, sout = 0. Outputs after reset: pout_a = pout_b = 0, zero_a = 1.
- sclr: same effect as rst.
- sset: all entries = SET_VALUE, ovf = 0, sout unchanged.
- op affects only entry[waddr]. Other entries, ovf bits and sout hold unless stated.
- Out-of-range address: if waddr >= DEPTH, op is ignored (no state change).
- LOAD: entry = pin.
- CLEAR: entry = 0 and ovf[waddr] = 0.
- SET: entry = SET_VALUE and ovf[waddr] = 0.
- SHL: entry = {entry[WIDTH-2:0], sin}; sout = old entry[WIDTH-1].
- SHR: entry = {sin, entry[WIDTH-1:1]}; sout = old entry[0].
- INC: entry + 1 (WIDTH-bit arithmetic).
  - At all-ones: SATURATE=0 wraps to 0; SATURATE=1 holds all-ones.
  - Either way ovf[waddr] set to 1.
- DEC: entry - 1.
  - At 0: SATURATE=0 wraps to all-ones; SATURATE=1 holds 0.
  - Either way ovf[waddr] set to 1.
- ovf bits are sticky. They clear only via rst, sclr, sset, or CLEAR/SET on that entry. LOAD does not clear ovf.
- Reads: pout_a, pout_b and zero_a are combinational from current entry contents. A write becomes visible the cycle after the edge, with no bypass.
- Out-of-range read address (raddr >= DEPTH) returns 0.
- Both read ports may address the same entry or the write target in the same cycle.
- Latency: 1 cycle from op presentation to updated pout.
- No state machine beyond per-entry registers and flags. All ops complete in a single cycle, with no busy or stall.

Test Plan:
- rst=1 for one edge after random traffic -> all pout = 0, ovf = 0, sout = 0, zero_a = 1. Then sset -> every entry reads 16'h0100, ovf = 0.
- LOAD 16'hA5A5 to entry 2, then SHL with sin=1 -> entry 2 = 16'h4B4B, sout = 1. Then SHR with sin=0 -> 16'h25A5, sout = 1.
- SATURATE=0: LOAD 16'hFFFF to entry 1, INC -> entry 1 = 0, ovf = 4'b0010. LOAD 16'h0005 -> ovf still 4'b0010. CLEAR entry 1 -> ovf = 0.
- SATURATE=1: DEC entry 0 at 0 -> stays 0, ovf[0] = 1. INC five times from 0 -> 5, no further ovf change.
- Same cycle: sclr=1, sset=1, op=LOAD 16'h1234 -> all entries 0. Next cycle: sset=1 with op=INC -> all entries 16'h0100, INC ignored.
- DEPTH=3 build: op=LOAD to waddr=3 -> no entry changes. raddr_a = 3 -> pout_a = 0, zero_a = 1.
